// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_arb_pkg
// Purpose  : Shared types, widths and sizing helpers for the SPI request arbiter
// Revision : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        BUSY  = 2'd2,
        ABORT = 2'd3
    } arb_state_e;

    localparam int SPI_W = 32;
    localparam int SEL_W = 2;

    // Watchdog counts 0..cycles-1, so $clog2(cycles) bits are always enough.
    function automatic int wdog_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

    function automatic int ptr_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage : spi_arb_pkg
`default_nettype wire

// File: rtl/spi_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : spi_rr_picker
// Purpose  : Combinational round-robin picker; first request after ptr wins
// Revision : 1.0 - initial release
// ============================================================================
module spi_rr_picker
    import spi_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int PTR_W = ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic             grant_valid,
    output logic [PTR_W-1:0] grant_idx
);

    logic [PTR_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest asserted request
    // is the last to overwrite the result.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = PTR_W'((int'(ptr) + off) % N_REQ);
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule : spi_rr_picker
`default_nettype wire

// File: rtl/spi_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_request_arbiter
// Purpose  : Round-robin sharing of one SPI shift engine between N_REQ users
// Revision : 1.0 - initial release
// ============================================================================
module spi_request_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [SPI_W*N_REQ-1:0] req_dat_i,
    input  logic [SEL_W*N_REQ-1:0] req_sel_i,
    output logic [N_REQ-1:0]       ack_o,
    output logic [N_REQ-1:0]       err_o,
    output logic [SPI_W-1:0]       rsp_dat_o,
    output logic                   busy_o,
    output logic [SPI_W-1:0]       SPI_O,
    output logic [SEL_W-1:0]       SPI_SEL_O,
    output logic                   SPI_STAR_O,
    input  logic [SPI_W-1:0]       SPI_I,
    input  logic                   SPI_DONE_I
);

    localparam int              PTR_W    = ptr_width(N_REQ);
    localparam int              WD_W     = wdog_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);

    arb_state_e       state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] gnt_q;
    logic [WD_W-1:0]  wd_q;
    logic [SPI_W-1:0] spi_dat_q;
    logic [SEL_W-1:0] spi_sel_q;
    logic             start_q;
    logic [SPI_W-1:0] rsp_q;
    logic [N_REQ-1:0] ack_q;
    logic [N_REQ-1:0] err_q;

    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [SPI_W-1:0] req_dat_arr [N_REQ];
    logic [SEL_W-1:0] req_sel_arr [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign req_dat_arr[k] = req_dat_i[k*SPI_W +: SPI_W];
        assign req_sel_arr[k] = req_sel_i[k*SEL_W +: SEL_W];
    end

    spi_rr_picker #(
        .N_REQ       (N_REQ)
    ) u_picker (
        .req         (req_i),
        .ptr         (ptr_q),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_RST;
            gnt_q     <= '0;
            wd_q      <= '0;
            spi_dat_q <= '0;
            spi_sel_q <= '0;
            start_q   <= 1'b0;
            rsp_q     <= '0;
            ack_q     <= '0;
            err_q     <= '0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q     <= pick_idx;
                        spi_dat_q <= req_dat_arr[pick_idx];
                        spi_sel_q <= req_sel_arr[pick_idx];
                        start_q   <= 1'b1;
                        wd_q      <= '0;
                        state_q   <= ARM;
                    end
                end
                ARM: begin
                    if (!SPI_DONE_I) begin
                        start_q <= 1'b0;
                        wd_q    <= '0;
                        state_q <= BUSY;
                    end else if (wd_q == WD_LIMIT) begin
                        start_q      <= 1'b0;
                        err_q[gnt_q] <= 1'b1;
                        ptr_q        <= gnt_q;
                        state_q      <= ABORT;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                BUSY: begin
                    // Completion wins over a watchdog expiry in the same cycle.
                    if (SPI_DONE_I) begin
                        rsp_q        <= SPI_I;
                        ack_q[gnt_q] <= 1'b1;
                        ptr_q        <= gnt_q;
                        state_q      <= IDLE;
                    end else if (wd_q == WD_LIMIT) begin
                        err_q[gnt_q] <= 1'b1;
                        ptr_q        <= gnt_q;
                        state_q      <= ABORT;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ABORT: begin
                    start_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    start_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack_o      = ack_q;
    assign err_o      = err_q;
    assign rsp_dat_o  = rsp_q;
    assign busy_o     = (state_q != IDLE);
    assign SPI_O      = spi_dat_q;
    assign SPI_SEL_O  = spi_sel_q;
    assign SPI_STAR_O = start_q;

endmodule : spi_request_arbiter
`default_nettype wire

// File: tb/tb_spi_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_request_arbiter
// Purpose  : Randomized self-checking bench with a transaction-level model
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_request_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [N-1:0]  req_i;
    logic [32*N-1:0] req_dat_i;
    logic [2*N-1:0]  req_sel_i;
    logic [N-1:0]  ack_o;
    logic [N-1:0]  err_o;
    logic [31:0]   rsp_dat_o;
    logic          busy_o;
    logic [31:0]   SPI_O;
    logic [1:0]    SPI_SEL_O;
    logic          SPI_STAR_O;
    logic [31:0]   SPI_I;
    logic          SPI_DONE_I;

    spi_request_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .req_i      (req_i),
        .req_dat_i  (req_dat_i),
        .req_sel_i  (req_sel_i),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .rsp_dat_o  (rsp_dat_o),
        .busy_o     (busy_o),
        .SPI_O      (SPI_O),
        .SPI_SEL_O  (SPI_SEL_O),
        .SPI_STAR_O (SPI_STAR_O),
        .SPI_I      (SPI_I),
        .SPI_DONE_I (SPI_DONE_I)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ptr_m;
    logic [2:0]  pending;
    logic [31:0] rsp_exp;
    int          ra, rb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference arbitration: first asserted request after the last winner.
    function automatic int pick(input logic [2:0] r, input int p);
        int idx;
        for (int i = 1; i <= N; i++) begin
            idx = (p + i) % N;
            if (r[idx[1:0]]) return idx;
        end
        return 0;
    endfunction

    task automatic rand_dat();
        req_dat_i = {$urandom, $urandom, $urandom};
        req_sel_i = 6'($urandom);
    endtask

    task automatic idle_gap(input int n);
        req_i = '0;
        repeat (n) begin
            @(posedge clk_i); #1;
            chk("idle_busy", 32'(busy_o), 32'd0);
            chk("idle_start", 32'(SPI_STAR_O), 32'd0);
            chk("idle_ack", 32'(ack_o), 32'd0);
            chk("idle_err", 32'(err_o), 32'd0);
        end
    endtask

    // a: edge index at which the engine first shows done=0 (accept);
    // b: number of edges done stays low. Values above TO mean "never".
    task automatic run_xfer(input logic [2:0] new_req, input int a, input int b,
                            input logic [31:0] word);
        int          w, e;
        bit          is_err;
        logic [31:0] exp_dat;
        logic [1:0]  exp_sel;
        pending = pending | new_req;
        if (pending == 3'b000) pending = 3'b001;
        req_i   = pending;
        w       = pick(pending, ptr_m);
        exp_dat = 32'(req_dat_i >> (32 * w));
        exp_sel = 2'(req_sel_i >> (2 * w));
        if (a > TO) begin
            is_err = 1'b1; e = TO;
        end else if (b > TO) begin
            is_err = 1'b1; e = a + TO;
        end else begin
            is_err = 1'b0; e = a + b;
        end
        @(posedge clk_i); #1;
        chk("grant_start", 32'(SPI_STAR_O), 32'd1);
        chk("grant_dat", SPI_O, exp_dat);
        chk("grant_sel", 32'(SPI_SEL_O), 32'(exp_sel));
        chk("grant_busy", 32'(busy_o), 32'd1);
        for (int k = 1; k <= e; k++) begin
            SPI_DONE_I = !(k >= a && k < a + b);
            SPI_I      = (k >= a + b) ? word : $urandom;
            rand_dat();
            if ($urandom_range(0, 3) == 0) req_i = req_i & ~(3'b001 << w);
            @(posedge clk_i); #1;
            chk("hold_dat", SPI_O, exp_dat);
            chk("hold_sel", 32'(SPI_SEL_O), 32'(exp_sel));
            chk("start", 32'(SPI_STAR_O), 32'((k < a) && (k != e)));
            if (k < e) begin
                chk("early_ack", 32'(ack_o), 32'd0);
                chk("early_err", 32'(err_o), 32'd0);
                chk("mid_busy", 32'(busy_o), 32'd1);
                chk("rsp_hold", rsp_dat_o, rsp_exp);
            end else if (!is_err) begin
                chk("ack", 32'(ack_o), 32'(3'b001 << w));
                chk("ack_err", 32'(err_o), 32'd0);
                chk("rsp", rsp_dat_o, word);
                chk("ack_busy", 32'(busy_o), 32'd0);
                rsp_exp = word;
            end else begin
                chk("err", 32'(err_o), 32'(3'b001 << w));
                chk("err_ack", 32'(ack_o), 32'd0);
                chk("err_rsp", rsp_dat_o, rsp_exp);
                chk("err_busy", 32'(busy_o), 32'd1);
            end
        end
        ptr_m      = w;
        pending    = pending & ~(3'b001 << w);
        req_i      = pending;
        SPI_DONE_I = 1'b1;
        if (is_err) begin
            @(posedge clk_i); #1;
            chk("post_err", 32'(err_o), 32'd0);
            chk("post_ack", 32'(ack_o), 32'd0);
            chk("post_busy", 32'(busy_o), 32'd0);
            chk("post_start", 32'(SPI_STAR_O), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_i    = 1'b1;
        req_i      = '0;
        req_dat_i  = '0;
        req_sel_i  = '0;
        SPI_I      = '0;
        SPI_DONE_I = 1'b1;
        pending    = '0;
        ptr_m      = N - 1;
        rsp_exp    = '0;
        #2;
        chk("rst_spi_o", SPI_O, 32'd0);
        chk("rst_sel", 32'(SPI_SEL_O), 32'd0);
        chk("rst_start", 32'(SPI_STAR_O), 32'd0);
        chk("rst_rsp", rsp_dat_o, 32'd0);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        idle_gap(2);

        // Single directed transfer from requester 0.
        rand_dat();
        req_dat_i[31:0] = 32'hA5A5_1234;
        req_sel_i[1:0]  = 2'd2;
        run_xfer(3'b001, 1, 8, 32'hDEAD_BEEF);

        // Asynchronous reset while start is high; requester 0 wins afterwards.
        rand_dat();
        pending = 3'b110;
        req_i   = pending;
        @(posedge clk_i); #1;
        chk("pre_rst_start", 32'(SPI_STAR_O), 32'd1);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_start", 32'(SPI_STAR_O), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_spi_o", SPI_O, 32'd0);
        chk("arst_rsp", rsp_dat_o, 32'd0);
        repeat (2) begin
            @(posedge clk_i); #1;
            chk("arst_ack", 32'(ack_o), 32'd0);
            chk("arst_err", 32'(err_o), 32'd0);
        end
        reset_i = 1'b0;
        ptr_m   = N - 1;
        rsp_exp = '0;
        rand_dat();
        run_xfer(3'b111, 2, 3, $urandom);

        // Fairness with every requester continuously asking.
        repeat (6) begin
            rand_dat();
            run_xfer(3'b111, $urandom_range(1, 3), $urandom_range(1, 6), $urandom);
        end

        // Watchdog in ARM, then a normal transfer; watchdog in BUSY; done
        // arriving exactly on the watchdog limit.
        rand_dat();
        run_xfer(3'b000, 1000, 1, $urandom);
        rand_dat();
        run_xfer(3'b010, 1, 4, $urandom);
        rand_dat();
        run_xfer(3'b100, 2, 1000, $urandom);
        rand_dat();
        run_xfer(3'b001, 1, TO, $urandom);

        for (int t = 0; t < 30; t++) begin
            ra = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(1, 15));
            rb = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(1, 16));
            rand_dat();
            run_xfer(3'($urandom_range(0, 7)), ra, rb, $urandom);
            if (pending == 3'b000 && $urandom_range(0, 1) == 1)
                idle_gap(int'($urandom_range(1, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_spi_request_arbiter
`default_nettype wire
